// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared types for the MIPS Avalon bus/load-store unit.
package mips_bus_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;
    typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD} size_t;
    typedef enum logic {GRANT_IF, GRANT_D} grant_t;

endpackage

// File: rtl/mips_lane_steer.sv
// mips_lane_steer: byte-lane enables, store-data replication and load extraction/extension.
module mips_lane_steer
    import mips_bus_pkg::*;
(
    input  size_t       size,
    input  logic [1:0]  off,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b       = rdata[{off, 3'b000} +: 8];
        h       = off[1] ? rdata[31:16] : rdata[15:0];
        be      = size == SIZE_BYTE ? 4'b0001 << off : size == SIZE_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_o = size == SIZE_BYTE ? {4{wdata[7:0]}} : size == SIZE_HALF ? {2{wdata[15:0]}} : wdata;
        rdata_o = size == SIZE_BYTE ? {{24{b[7] & ~uns}}, b} : size == SIZE_HALF ? {{16{h[15] & ~uns}}, h} : rdata;
    end

endmodule

// File: rtl/mips_bus_lsu.sv
// mips_bus_lsu: fetch/data request arbiter driving one Avalon-MM master,
// with lane steering, misalignment detection and a bus-hang timeout.
module mips_bus_lsu
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit DATA_PRIORITY  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              busy,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    input  logic              waitrequest,
    output logic [31:0]       writedata,
    output logic [3:0]        byteenable,
    input  logic [31:0]       readdata
);
    localparam int CNT_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_t        state_q, state_d;
    grant_t            grant_q, grant_d, last_q, last_d;
    size_t             size_q, size_d, req_size, sel_size;
    logic [1:0]        off_q, off_d, sel_off;
    logic              uns_q, uns_d, we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] address_q, address_d, req_addr;
    logic              read_q, read_d, write_q, write_d;
    logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]        be_q, be_d;
    logic              err_q, err_d, if_ack_q, if_ack_d, d_ack_q, d_ack_d;
    logic              pick_d, misalign, timed_out;
    logic [3:0]        ls_be;
    logic [31:0]       ls_wdata, ls_rdata;

    always_comb begin
        pick_d    = (if_req && d_req) ? (DATA_PRIORITY ? last_q != GRANT_D : last_q == GRANT_IF) : d_req;
        req_size  = !pick_d ? SIZE_WORD : d_size == 2'b00 ? SIZE_BYTE : d_size == 2'b01 ? SIZE_HALF : SIZE_WORD;
        req_addr  = pick_d ? d_addr : if_addr;
        misalign  = req_size == SIZE_HALF ? req_addr[0] : req_size == SIZE_WORD ? |req_addr[1:0] : 1'b0;
        sel_size  = state_q == IDLE ? req_size : size_q;
        sel_off   = state_q == IDLE ? req_addr[1:0] : off_q;
        timed_out = TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST;
    end

    mips_lane_steer u_steer (
        .size    (sel_size),
        .off     (sel_off),
        .uns     (uns_q),
        .wdata   (d_wdata),
        .rdata   (readdata),
        .be      (ls_be),
        .wdata_o (ls_wdata),
        .rdata_o (ls_rdata)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        size_d    = size_q;
        off_d     = off_q;
        uns_d     = uns_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        address_d = address_q;
        read_d    = read_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        if_ack_d  = 1'b0;
        d_ack_d   = 1'b0;
        case (state_q)
            IDLE: if (if_req || d_req) begin
                grant_d = pick_d ? GRANT_D : GRANT_IF;
                last_d  = grant_d;
                if (misalign) begin
                    state_d  = RESP;
                    rdata_d  = '0;
                    err_d    = 1'b1;
                    if_ack_d = !pick_d;
                    d_ack_d  = pick_d;
                end else begin
                    state_d   = ACCESS;
                    size_d    = req_size;
                    off_d     = req_addr[1:0];
                    uns_d     = pick_d && d_unsigned;
                    we_d      = pick_d && d_we;
                    cnt_d     = '0;
                    address_d = {req_addr[ADDR_W-1:2], 2'b00};
                    read_d    = !we_d;
                    write_d   = we_d;
                    wdata_d   = ls_wdata;
                    be_d      = ls_be;
                end
            end
            ACCESS: if (!waitrequest || timed_out) begin
                state_d  = RESP;
                read_d   = 1'b0;
                write_d  = 1'b0;
                rdata_d  = (waitrequest || we_q) ? '0 : ls_rdata;
                err_d    = waitrequest;
                if_ack_d = grant_q == GRANT_IF;
                d_ack_d  = grant_q == GRANT_D;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant_q   <= GRANT_IF;
            last_q    <= GRANT_IF;
            size_q    <= SIZE_BYTE;
            off_q     <= '0;
            uns_q     <= 1'b0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            address_q <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            if_ack_q  <= 1'b0;
            d_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            size_q    <= size_d;
            off_q     <= off_d;
            uns_q     <= uns_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            address_q <= address_d;
            read_q    <= read_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            if_ack_q  <= if_ack_d;
            d_ack_q   <= d_ack_d;
        end
    end

    assign if_ack     = if_ack_q;
    assign d_ack      = d_ack_q;
    assign if_rdata   = rdata_q;
    assign d_rdata    = rdata_q;
    assign if_err     = err_q;
    assign d_err      = err_q;
    assign busy       = state_q != IDLE;
    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = wdata_q;
    assign byteenable = be_q;

endmodule
